// File: rtl/multicycle_control.sv
// Multi-cycle instruction control FSM: accepts an opcode/funct pair, decodes the ALU op,
// sequences ALU start, waits for shift completion, writes back. Optional trapping: CTRL_TRAP_EN.
module multicycle_control #(
  parameter int unsigned OPW  = 6,
  parameter int unsigned FW   = 4,
  parameter int unsigned AOPW = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [OPW-1:0]  opcode,
  input  logic [FW-1:0]   funct,
  input  logic            alu_done,
  output logic            instr_ready,
  output logic [AOPW-1:0] alu_op,
  output logic            alu_start,
  output logic            reg_we,
  output logic            busy,
  output logic [CNTW-1:0] retired,
  output logic            illegal
);

  localparam int unsigned     LastFunct = 8;
  localparam logic [AOPW-1:0] AluNop    = '1;
  localparam logic [AOPW-1:0] AluSla    = AOPW'(6);
  localparam logic [AOPW-1:0] AluSra    = AOPW'(7);
  localparam logic [AOPW-1:0] AluSrl    = AOPW'(8);

`ifdef CTRL_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_WB} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OPW-1:0]  r_opcode;
  logic [FW-1:0]   r_funct;
  logic [AOPW-1:0] r_alu_op;
  logic [AOPW-1:0] w_alu_op_nxt;
  logic            r_instr_ready;
  logic            r_alu_start;
  logic            r_reg_we;
  logic            r_busy;
  logic [CNTW-1:0] r_retired;
  logic            w_rtype;
  logic            w_legal;
  logic            w_is_shift;

  // Next-state and decode
  always_comb begin
    w_state_nxt  = r_state;
    w_alu_op_nxt = r_alu_op;
    w_rtype      = (r_opcode == '0);
    w_legal      = w_rtype && (32'(r_funct) <= LastFunct);
    w_is_shift   = (r_alu_op == AluSla) || (r_alu_op == AluSra) || (r_alu_op == AluSrl);
    case (r_state)
      S_IDLE: begin
        if (instr_valid) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_alu_op_nxt = w_legal ? AOPW'(r_funct) : AluNop;
        w_state_nxt  = S_EXEC;
`ifdef CTRL_TRAP_EN
        if (w_rtype && !w_legal) w_state_nxt = S_TRAP;
`endif
      end
      S_EXEC: begin
        w_state_nxt = w_is_shift ? S_WAIT : S_WB;
      end
      S_WAIT: begin
        if (alu_done) w_state_nxt = S_WB;
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_funct       <= '0;
      r_alu_op      <= AluNop;
      r_instr_ready <= 1'b1;
      r_alu_start   <= 1'b0;
      r_reg_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_retired     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && instr_valid) begin
        r_opcode <= opcode;
        r_funct  <= funct;
      end
      r_alu_op      <= w_alu_op_nxt;
      r_instr_ready <= (w_state_nxt == S_IDLE);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_alu_start   <= (w_state_nxt == S_EXEC);
      r_reg_we      <= (w_state_nxt == S_WB) && (w_alu_op_nxt != AluNop);
      if ((r_state == S_WB) && r_reg_we) r_retired <= r_retired + CNTW'(1);
    end
  end

`ifdef CTRL_TRAP_EN
  logic r_illegal;

  // Sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_state_nxt == S_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign instr_ready = r_instr_ready;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign reg_we      = r_reg_we;
  assign busy        = r_busy;
  assign retired     = r_retired;

endmodule
